// File: rtl/dmem_req_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_req_tracker_if
//  Purpose  : Bundles the core request, D-cache request, D-cache response and
//             core response channels used by dmem_req_tracker. The tracker
//             connects through the 'slave' modport. The core / cache side,
//             or a testbench, connects through the 'master' modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_req_tracker_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8,
  parameter int META_W = 8
);
  // Core -> tracker request channel
  logic              core_req_valid;
  logic              core_req_ready;
  logic [4:0]        core_req_cmd;
  logic [2:0]        core_req_typ;
  logic [ADDR_W-1:0] core_req_addr;
  logic [DATA_W-1:0] core_req_data;
  logic [META_W-1:0] core_req_meta;

  // Tracker -> cache request channel
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [4:0]        dmem_req_cmd;
  logic [2:0]        dmem_req_typ;
  logic [ADDR_W-1:0] dmem_req_bits_addr;
  logic [DATA_W-1:0] dmem_req_bits_data;
  logic [TAG_W-1:0]  dmem_req_bits_tag;

  // Cache -> tracker response channel
  logic              dmem_resp_valid;
  logic [TAG_W-1:0]  dmem_resp_bits_tag;
  logic              dmem_resp_bits_nack;
  logic [DATA_W-1:0] dmem_resp_bits_data;

  // Tracker -> core response channel (no backpressure)
  logic              core_resp_valid;
  logic [DATA_W-1:0] core_resp_data;
  logic [META_W-1:0] core_resp_meta;
  logic              core_resp_err;

  // Environment side: drives core requests and cache responses
  modport master (
    output core_req_valid, core_req_cmd, core_req_typ, core_req_addr,
           core_req_data, core_req_meta,
    input  core_req_ready,
    input  dmem_req_valid, dmem_req_cmd, dmem_req_typ, dmem_req_bits_addr,
           dmem_req_bits_data, dmem_req_bits_tag,
    output dmem_req_ready,
    output dmem_resp_valid, dmem_resp_bits_tag, dmem_resp_bits_nack,
           dmem_resp_bits_data,
    input  core_resp_valid, core_resp_data, core_resp_meta, core_resp_err
  );

  // Tracker side
  modport slave (
    input  core_req_valid, core_req_cmd, core_req_typ, core_req_addr,
           core_req_data, core_req_meta,
    output core_req_ready,
    output dmem_req_valid, dmem_req_cmd, dmem_req_typ, dmem_req_bits_addr,
           dmem_req_bits_data, dmem_req_bits_tag,
    input  dmem_req_ready,
    input  dmem_resp_valid, dmem_resp_bits_tag, dmem_resp_bits_nack,
           dmem_resp_bits_data,
    output core_resp_valid, core_resp_data, core_resp_meta, core_resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_req_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_req_tracker
//  Purpose  : Outstanding-request tracker between the core memory stage and
//             the D-cache port. Holds up to NUM_ENTRIES in-flight requests,
//             tags them with their entry index, replays NACKed requests and
//             returns responses with the core metadata attached.
//  Options  : define DMEM_TRK_PERF_EN to add saturating NACK / retire
//             performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_req_tracker #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 40,
  parameter int DATA_W      = 64,
  parameter int TAG_W       = 8,
  parameter int META_W      = 8,
  parameter int MAX_RETRY   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  dmem_req_tracker_if.slave   bus,
  output logic                busy_o,
  output logic                spurious_resp_o
`ifdef DMEM_TRK_PERF_EN
  ,
  output logic [31:0]         perf_nack_cnt_o,
  output logic [31:0]         perf_retire_cnt_o
`endif
);

  localparam int IDX_W   = $clog2(NUM_ENTRIES);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   C_LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);

  // FREE: empty. PEND: waiting to issue. SENT: at the cache.
  // DRAIN: at the cache but flushed; its response is swallowed.
  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_SENT  = 2'd2,
    ST_DRAIN = 2'd3
  } entry_state_e;

  entry_state_e        state_q [NUM_ENTRIES];
  logic [RETRY_W-1:0]  retry_q [NUM_ENTRIES];
  logic [4:0]          cmd_q   [NUM_ENTRIES];
  logic [2:0]          typ_q   [NUM_ENTRIES];
  logic [ADDR_W-1:0]   addr_q  [NUM_ENTRIES];
  logic [DATA_W-1:0]   data_q  [NUM_ENTRIES];
  logic [META_W-1:0]   meta_q  [NUM_ENTRIES];

  logic [IDX_W-1:0]    rr_q;
  logic                lock_q;
  logic [IDX_W-1:0]    lock_idx_q;
  logic                spurious_q;

  logic                core_resp_valid_q;
  logic [DATA_W-1:0]   core_resp_data_q;
  logic [META_W-1:0]   core_resp_meta_q;
  logic                core_resp_err_q;

  logic                w_alloc_found;
  logic [IDX_W-1:0]    w_alloc_idx;
  logic                w_sel_found;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_core_ready;
  logic                w_core_hs;
  logic                w_dmem_hs;
  logic                w_busy;

  logic                w_resp_in_range;
  logic [IDX_W-1:0]    w_resp_idx;
  logic                w_resp_hit;
  logic                w_resp_live;
  logic                w_resp_ok;
  logic                w_resp_retry;
  logic                w_resp_fail;

  // Lowest-index free entry receives the next core request.
  always_comb begin : alloc_select
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Issue select: keep a stalled entry presented, otherwise round-robin over PEND.
  always_comb begin : issue_select
    logic [IDX_W:0] v_j;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    v_j         = '0;
    if (lock_q && (state_q[lock_idx_q] == ST_PEND)) begin
      w_sel_found = 1'b1;
      w_sel_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        v_j = {1'b0, rr_q} + (IDX_W+1)'(k);
        if (v_j >= (IDX_W+1)'(NUM_ENTRIES)) begin
          v_j = v_j - (IDX_W+1)'(NUM_ENTRIES);
        end
        if (!w_sel_found && (state_q[v_j[IDX_W-1:0]] == ST_PEND)) begin
          w_sel_found = 1'b1;
          w_sel_idx   = v_j[IDX_W-1:0];
        end
      end
    end
  end

  // Occupancy summary for the busy output.
  always_comb begin : busy_calc
    w_busy = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] != ST_FREE) begin
        w_busy = 1'b1;
      end
    end
  end

  // Ready is held low while in reset so nothing is accepted then.
  assign w_core_ready = w_alloc_found & ~flush_i & ~rst;
  assign w_core_hs    = bus.core_req_valid & w_core_ready;
  assign w_dmem_hs    = w_sel_found & bus.dmem_req_ready;

  // Response decode. Only SENT/DRAIN entries may be hit; anything else is spurious.
  assign w_resp_in_range = ({1'b0, bus.dmem_resp_bits_tag} < (TAG_W+1)'(NUM_ENTRIES));
  assign w_resp_idx      = bus.dmem_resp_bits_tag[IDX_W-1:0];
  assign w_resp_hit      = bus.dmem_resp_valid & w_resp_in_range &
                           ((state_q[w_resp_idx] == ST_SENT) ||
                            (state_q[w_resp_idx] == ST_DRAIN));
  // A flush in the same cycle drops the response of a SENT entry.
  assign w_resp_live     = w_resp_hit & (state_q[w_resp_idx] == ST_SENT) & ~flush_i;
  assign w_resp_ok       = w_resp_live & ~bus.dmem_resp_bits_nack;
  assign w_resp_retry    = w_resp_live &  bus.dmem_resp_bits_nack &
                           (retry_q[w_resp_idx] < C_MAX_RETRY);
  assign w_resp_fail     = w_resp_live &  bus.dmem_resp_bits_nack &
                           (retry_q[w_resp_idx] == C_MAX_RETRY);

  // Per-entry state machines and request payload storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        retry_q[i] <= '0;
        cmd_q[i]   <= '0;
        typ_q[i]   <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        meta_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        unique case (state_q[i])
          ST_FREE: begin
            if (w_core_hs && (w_alloc_idx == IDX_W'(i))) begin
              state_q[i] <= ST_PEND;
              retry_q[i] <= '0;
              cmd_q[i]   <= bus.core_req_cmd;
              typ_q[i]   <= bus.core_req_typ;
              addr_q[i]  <= bus.core_req_addr;
              data_q[i]  <= bus.core_req_data;
              meta_q[i]  <= bus.core_req_meta;
            end
          end
          ST_PEND: begin
            if (w_dmem_hs && (w_sel_idx == IDX_W'(i))) begin
              state_q[i] <= flush_i ? ST_DRAIN : ST_SENT;
            end else if (flush_i) begin
              state_q[i] <= ST_FREE;
            end
          end
          ST_SENT: begin
            if (w_resp_hit && (w_resp_idx == IDX_W'(i))) begin
              if (w_resp_retry) begin
                state_q[i] <= ST_PEND;
                retry_q[i] <= retry_q[i] + RETRY_W'(1);
              end else begin
                state_q[i] <= ST_FREE;
              end
            end else if (flush_i) begin
              state_q[i] <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_resp_hit && (w_resp_idx == IDX_W'(i))) begin
              state_q[i] <= ST_FREE;
            end
          end
          default: state_q[i] <= ST_FREE;
        endcase
      end
    end
  end

  // Round-robin pointer advance and stall lock for the cache request port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= w_sel_found & ~bus.dmem_req_ready;
      lock_idx_q <= w_sel_idx;
      if (w_dmem_hs) begin
        rr_q <= (w_sel_idx == C_LAST_IDX) ? '0 : (w_sel_idx + IDX_W'(1));
      end
    end
  end

  // Registered core response and sticky spurious-response flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_resp_valid_q <= 1'b0;
      core_resp_data_q  <= '0;
      core_resp_meta_q  <= '0;
      core_resp_err_q   <= 1'b0;
      spurious_q        <= 1'b0;
    end else begin
      core_resp_valid_q <= w_resp_ok | w_resp_fail;
      core_resp_err_q   <= w_resp_fail;
      if (w_resp_ok || w_resp_fail) begin
        core_resp_data_q <= bus.dmem_resp_bits_data;
        core_resp_meta_q <= meta_q[w_resp_idx];
      end
      if (bus.dmem_resp_valid && !w_resp_hit) begin
        spurious_q <= 1'b1;
      end
    end
  end

`ifdef DMEM_TRK_PERF_EN
  logic [31:0] perf_nack_q;
  logic [31:0] perf_retire_q;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_nack_q   <= '0;
      perf_retire_q <= '0;
    end else begin
      if (w_resp_hit && bus.dmem_resp_bits_nack && (perf_nack_q != '1)) begin
        perf_nack_q <= perf_nack_q + 32'd1;
      end
      if (core_resp_valid_q && (perf_retire_q != '1)) begin
        perf_retire_q <= perf_retire_q + 32'd1;
      end
    end
  end

  assign perf_nack_cnt_o   = perf_nack_q;
  assign perf_retire_cnt_o = perf_retire_q;
`endif

  assign bus.core_req_ready     = w_core_ready;
  assign bus.dmem_req_valid     = w_sel_found;
  assign bus.dmem_req_cmd       = cmd_q[w_sel_idx];
  assign bus.dmem_req_typ       = typ_q[w_sel_idx];
  assign bus.dmem_req_bits_addr = addr_q[w_sel_idx];
  assign bus.dmem_req_bits_data = data_q[w_sel_idx];
  assign bus.dmem_req_bits_tag  = TAG_W'(w_sel_idx);
  assign bus.core_resp_valid    = core_resp_valid_q;
  assign bus.core_resp_data     = core_resp_data_q;
  assign bus.core_resp_meta     = core_resp_meta_q;
  assign bus.core_resp_err      = core_resp_err_q;
  assign busy_o                 = w_busy;
  assign spurious_resp_o        = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_req_tracker
//  Purpose  : Self-checking bench for dmem_req_tracker: directed scenarios
//             followed by random core/cache traffic, all compared against a
//             transaction-level model of the tracker's rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_req_tracker;
  localparam int N         = 4;
  localparam int ADDR_W    = 40;
  localparam int DATA_W    = 64;
  localparam int TAG_W     = 8;
  localparam int META_W    = 8;
  localparam int MAX_RETRY = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  logic spur;
`ifdef DMEM_TRK_PERF_EN
  logic [31:0] perf_nack;
  logic [31:0] perf_ret;
`endif

  dmem_req_tracker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .META_W(META_W)) ifc ();

  dmem_req_tracker #(
    .NUM_ENTRIES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .META_W(META_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .bus             (ifc),
    .busy_o          (busy),
    .spurious_resp_o (spur)
`ifdef DMEM_TRK_PERF_EN
    ,
    .perf_nack_cnt_o   (perf_nack),
    .perf_retire_cnt_o (perf_ret)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: each slot is either empty, waiting to be issued,
  // or out at the cache (possibly killed by a flush).
  bit                m_alloc  [N];
  bit                m_issued [N];
  bit                m_killed [N];
  logic [4:0]        m_cmd    [N];
  logic [2:0]        m_typ    [N];
  logic [ADDR_W-1:0] m_addr   [N];
  logic [DATA_W-1:0] m_data   [N];
  logic [META_W-1:0] m_meta   [N];
  int                m_nacks  [N];
  int                m_rr;
  bit                m_lock;
  int                m_lock_idx;
  bit                m_spur;
  int                m_nack_cnt;
  int                m_ret_cnt;
  bit                e_rv;
  bit                e_err;
  logic [DATA_W-1:0] e_data;
  logic [META_W-1:0] e_meta;
  int                obs_hs;
  int                obs_tags[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_alloc[i] = 0; m_issued[i] = 0; m_killed[i] = 0; m_nacks[i] = 0;
    end
    m_rr = 0; m_lock = 0; m_lock_idx = 0; m_spur = 0;
    m_nack_cnt = 0; m_ret_cnt = 0; e_rv = 0; e_err = 0;
  endtask

  task automatic idle_inputs();
    ifc.core_req_valid      = 1'b0;
    ifc.dmem_req_ready      = 1'b0;
    ifc.dmem_resp_valid     = 1'b0;
    ifc.dmem_resp_bits_tag  = '0;
    ifc.dmem_resp_bits_nack = 1'b0;
    ifc.dmem_resp_bits_data = '0;
    flush                   = 1'b0;
  endtask

  task automatic drive_core(input bit v);
    ifc.core_req_valid = v;
    ifc.core_req_cmd   = 5'($urandom_range(0, 31));
    ifc.core_req_typ   = 3'($urandom_range(0, 7));
    ifc.core_req_addr  = ADDR_W'({$urandom(), $urandom()});
    ifc.core_req_data  = {$urandom(), $urandom()};
    ifc.core_req_meta  = META_W'($urandom());
  endtask

  task automatic drive_resp(input bit v, input int tag, input bit nack);
    ifc.dmem_resp_valid     = v;
    ifc.dmem_resp_bits_tag  = TAG_W'(tag);
    ifc.dmem_resp_bits_nack = nack;
    ifc.dmem_resp_bits_data = {$urandom(), $urandom()};
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model
  // with this cycle's inputs, then return 1ns after the rising edge.
  task automatic step();
    int  free_idx, sel, t, j;
    bit  sel_ok, exp_ready, any_busy, hs;
    bit  pre_wait [N];
    bit  pre_sent [N];
    bit  resp_on  [N];
    @(negedge clk);
    free_idx = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_alloc[i]) free_idx = i;
    exp_ready = (free_idx >= 0) && !flush;
    sel_ok = 0; sel = 0;
    if (m_lock && m_alloc[m_lock_idx] && !m_issued[m_lock_idx]) begin
      sel_ok = 1; sel = m_lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!sel_ok && m_alloc[j] && !m_issued[j]) begin sel_ok = 1; sel = j; end
      end
    end
    any_busy = 0;
    for (int i = 0; i < N; i++) if (m_alloc[i]) any_busy = 1;

    check_val("core_req_ready", ifc.core_req_ready, exp_ready);
    check_val("dmem_req_valid", ifc.dmem_req_valid, sel_ok);
    if (sel_ok) begin
      check_val("dmem_req_tag",  ifc.dmem_req_bits_tag,  sel);
      check_val("dmem_req_addr", ifc.dmem_req_bits_addr, m_addr[sel]);
      check_val("dmem_req_data", ifc.dmem_req_bits_data, m_data[sel]);
      check_val("dmem_req_cmd",  ifc.dmem_req_cmd,       m_cmd[sel]);
      check_val("dmem_req_typ",  ifc.dmem_req_typ,       m_typ[sel]);
    end
    check_val("core_resp_valid", ifc.core_resp_valid, e_rv);
    if (e_rv) begin
      check_val("core_resp_meta", ifc.core_resp_meta, e_meta);
      check_val("core_resp_err",  ifc.core_resp_err,  e_err);
      if (!e_err) check_val("core_resp_data", ifc.core_resp_data, e_data);
    end
    check_val("busy", busy, any_busy);
    check_val("spurious_resp", spur, m_spur);

    if (ifc.dmem_req_valid && ifc.dmem_req_ready) begin
      obs_hs++;
      obs_tags.push_back(int'(ifc.dmem_req_bits_tag));
    end

    for (int i = 0; i < N; i++) begin
      pre_wait[i] = m_alloc[i] && !m_issued[i];
      pre_sent[i] = m_alloc[i] && m_issued[i] && !m_killed[i];
      resp_on[i]  = 0;
    end
    e_rv = 0; e_err = 0;
    if (e_rv) m_ret_cnt++;
    if (ifc.dmem_resp_valid) begin
      t = int'(ifc.dmem_resp_bits_tag);
      if (t < N && m_alloc[t] && m_issued[t]) begin
        resp_on[t] = 1;
        if (ifc.dmem_resp_bits_nack) m_nack_cnt++;
        if (m_killed[t] || flush) begin
          m_alloc[t] = 0;
        end else if (!ifc.dmem_resp_bits_nack) begin
          e_rv = 1; e_data = ifc.dmem_resp_bits_data; e_meta = m_meta[t];
          m_alloc[t] = 0;
        end else if (m_nacks[t] < MAX_RETRY) begin
          m_nacks[t]++; m_issued[t] = 0;
        end else begin
          e_rv = 1; e_err = 1; e_meta = m_meta[t];
          m_alloc[t] = 0;
        end
      end else begin
        m_spur = 1;
      end
    end
    if (e_rv) m_ret_cnt++;
    hs = sel_ok && ifc.dmem_req_ready;
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (pre_wait[i] && !(hs && sel == i)) m_alloc[i] = 0;
        if (pre_sent[i] && !resp_on[i]) m_killed[i] = 1;
      end
    end
    if (hs) begin
      m_issued[sel] = 1;
      m_killed[sel] = flush;
      m_rr = (sel + 1) % N;
    end
    m_lock = sel_ok && !ifc.dmem_req_ready;
    m_lock_idx = sel;
    if (ifc.core_req_valid && exp_ready) begin
      m_alloc[free_idx]  = 1; m_issued[free_idx] = 0; m_killed[free_idx] = 0;
      m_nacks[free_idx]  = 0;
      m_cmd[free_idx]    = ifc.core_req_cmd;
      m_typ[free_idx]    = ifc.core_req_typ;
      m_addr[free_idx]   = ifc.core_req_addr;
      m_data[free_idx]   = ifc.core_req_data;
      m_meta[free_idx]   = ifc.core_req_meta;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs0, tags[$], pick;
    logic [ADDR_W-1:0] stall_addr;
    model_reset();
    idle_inputs();
    drive_core(1'b1);
    obs_hs = 0;
    repeat (3) @(posedge clk);
    #1;
    // In reset: nothing accepted, all outputs cleared
    check_val("reset_core_req_ready", ifc.core_req_ready, 1'b0);
    check_val("reset_dmem_req_valid", ifc.dmem_req_valid, 1'b0);
    check_val("reset_core_resp_valid", ifc.core_resp_valid, 1'b0);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_spurious", spur, 1'b0);
    idle_inputs();
    rst = 1'b0;

    // Single load, addr 0x80 meta 0x11, data 0xDEAD back
    ifc.dmem_req_ready = 1'b1;
    drive_core(1'b1);
    ifc.core_req_addr = ADDR_W'(40'h80);
    ifc.core_req_meta = 8'h11;
    step();
    ifc.core_req_valid = 1'b0;
    step();
    drive_resp(1'b1, 0, 1'b0);
    ifc.dmem_resp_bits_data = 64'hDEAD;
    step();
    drive_resp(1'b0, 0, 1'b0);
    check_val("single_resp_valid", ifc.core_resp_valid, 1'b1);
    check_val("single_resp_data", ifc.core_resp_data, 64'hDEAD);
    check_val("single_resp_meta", ifc.core_resp_meta, 8'h11);
    check_val("single_resp_err", ifc.core_resp_err, 1'b0);
    step();

    // Fill all four entries while the cache withholds responses
    for (int i = 0; i < 4; i++) begin drive_core(1'b1); step(); end
    ifc.core_req_valid = 1'b0;
    check_val("full_ready", ifc.core_req_ready, 1'b0);
    check_val("full_busy", busy, 1'b1);
    step();
    drive_resp(1'b1, 2, 1'b0); step();
    drive_resp(1'b0, 0, 1'b0);
    check_val("freed_ready", ifc.core_req_ready, 1'b1);
    drive_resp(1'b1, 0, 1'b0); step();
    drive_resp(1'b1, 1, 1'b0); step();
    drive_resp(1'b1, 3, 1'b0); step();
    drive_resp(1'b0, 0, 1'b0); step();

    // 16 NACKs on one request: 15 replays then an error retire
    drive_core(1'b1); step();
    ifc.core_req_valid = 1'b0;
    hs0 = obs_hs;
    for (int i = 0; i < 16; i++) begin
      step();
      drive_resp(1'b1, 0, 1'b1); step();
      drive_resp(1'b0, 0, 1'b0);
    end
    check_val("nack_issue_count", obs_hs - hs0, 16);
    check_val("nack_err_valid", ifc.core_resp_valid, 1'b1);
    check_val("nack_err_flag", ifc.core_resp_err, 1'b1);
    step();

    // Two SENT plus one PEND, then flush
    for (int i = 0; i < 3; i++) begin drive_core(1'b1); step(); end
    ifc.core_req_valid = 1'b0;
    ifc.dmem_req_ready = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0;
    drive_resp(1'b1, 0, 1'b0); step();
    check_val("flush_resp0_dropped", ifc.core_resp_valid, 1'b0);
    drive_resp(1'b1, 1, 1'b1); step();
    drive_resp(1'b0, 0, 1'b0);
    check_val("flush_resp1_dropped", ifc.core_resp_valid, 1'b0);
    check_val("flush_busy_low", busy, 1'b0);

    // Cache stalls with three pending: outputs hold, then issue 0,1,2
    drive_core(1'b1);
    stall_addr = ifc.core_req_addr;
    for (int i = 0; i < 3; i++) begin step(); drive_core(1'b1); end
    ifc.core_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall_tag", ifc.dmem_req_bits_tag, 0);
      check_val("stall_addr", ifc.dmem_req_bits_addr, stall_addr);
    end
    obs_tags.delete();
    ifc.dmem_req_ready = 1'b1;
    repeat (3) step();
    check_val("rr_count", obs_tags.size(), 3);
    for (int i = 0; i < 3 && i < obs_tags.size(); i++) check_val("rr_order", obs_tags[i], i);
    for (int i = 0; i < 3; i++) begin drive_resp(1'b1, i, 1'b0); step(); end
    drive_resp(1'b0, 0, 1'b0); step();

    // Out-of-range tag is spurious and produces no core response
    drive_resp(1'b1, 7, 1'b0); step();
    drive_resp(1'b0, 0, 1'b0);
    check_val("spurious_set", spur, 1'b1);
    check_val("spurious_no_resp", ifc.core_resp_valid, 1'b0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      drive_core($urandom_range(0, 1) == 1);
      ifc.dmem_req_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tags.delete();
      for (int i = 0; i < N; i++) if (m_alloc[i] && m_issued[i]) tags.push_back(i);
      if ($urandom_range(0, 199) == 0) begin
        drive_resp(1'b1, $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      end else if (tags.size() > 0 && $urandom_range(0, 2) == 0) begin
        pick = tags[$urandom_range(0, tags.size() - 1)];
        drive_resp(1'b1, pick, $urandom_range(0, 3) == 0);
      end else begin
        drive_resp(1'b0, 0, 1'b0);
      end
      step();
    end
    idle_inputs();
    step();
    step();
`ifdef DMEM_TRK_PERF_EN
    check_val("perf_nack", perf_nack, m_nack_cnt);
    check_val("perf_retire", perf_ret, m_ret_cnt);
`endif

    // Reset in the middle of traffic; a late response then counts as spurious
    drive_core(1'b1);
    ifc.dmem_req_ready = 1'b0;
    step();
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ready", ifc.core_req_ready, 1'b0);
    check_val("midrst_dmem_valid", ifc.dmem_req_valid, 1'b0);
    check_val("midrst_spurious", spur, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_resp(1'b1, 1, 1'b0); step();
    drive_resp(1'b0, 0, 1'b0);
    check_val("late_resp_spurious", spur, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
